// File: rtl/bp_cache_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bp_cache_req_arbiter_pkg
// Brief   : Shared types and helpers for the cache-miss request arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package bp_cache_req_arbiter_pkg;

  localparam int c_max_ch      = 8;
  localparam int c_ch_id_width = 3;

  typedef logic [c_ch_id_width-1:0] bp_cache_ch_id_t;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_cache_req_order_fifo.sv
`default_nettype none
// ============================================================================
// Module  : bp_cache_req_order_fifo
// Brief   : Small channel-ID FIFO recording grant order.
// Revision: 1.0 - initial release
// ============================================================================
module bp_cache_req_order_fifo
  import bp_cache_req_arbiter_pkg::*;
#(
  parameter int depth_p = 2,
  parameter int width_p = c_ch_id_width
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               empty_o
);

  localparam int c_ptr_width = safe_clog2(depth_p);
  localparam int c_cnt_width = safe_clog2(depth_p + 1);
  localparam logic [c_ptr_width-1:0] c_last_ptr = c_ptr_width'(depth_p - 1);
  localparam logic [c_cnt_width-1:0] c_depth    = c_cnt_width'(depth_p);

  logic [width_p-1:0]     r_mem [depth_p];
  logic [c_ptr_width-1:0] r_wr_ptr;
  logic [c_ptr_width-1:0] r_rd_ptr;
  logic [c_cnt_width-1:0] r_count;
  logic                   w_push;
  logic                   w_pop;

  assign w_push  = push_i & (r_count != c_depth);
  assign w_pop   = pop_i & (r_count != '0);
  assign data_o  = r_mem[r_rd_ptr];
  assign empty_o = (r_count == '0);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < depth_p; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bp_cache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bp_cache_req_arbiter
// Brief   : Round-robin N-channel cache-miss arbiter onto one LCE request port.
// Revision: 1.0 - initial release
// ============================================================================
module bp_cache_req_arbiter
  import bp_cache_req_arbiter_pkg::*;
#(
  parameter  int num_ch_p         = 2,
  parameter  int req_width_p      = 64,
  parameter  int metadata_width_p = 8,
  localparam int ch_id_width_lp   = safe_clog2(num_ch_p)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [num_ch_p*req_width_p-1:0]      cache_req_i,
  input  logic [num_ch_p-1:0]                  cache_req_v_i,
  output logic [num_ch_p-1:0]                  cache_req_ready_o,
  input  logic [num_ch_p*metadata_width_p-1:0] cache_req_metadata_i,
  input  logic [num_ch_p-1:0]                  cache_req_metadata_v_i,
  output logic [num_ch_p-1:0]                  cache_req_complete_o,
  output logic [req_width_p-1:0]               cache_req_o,
  output logic                                 cache_req_v_o,
  input  logic                                 cache_req_ready_i,
  output logic [metadata_width_p-1:0]          cache_req_metadata_o,
  output logic                                 cache_req_metadata_v_o,
  input  logic                                 cache_req_complete_i,
  output logic [ch_id_width_lp-1:0]            owner_o,
  output logic                                 busy_o,
  output logic                                 err_o
);

  logic                        r_active;
  logic [num_ch_p-1:0]         r_pending;
  logic [num_ch_p-1:0]         r_meta_vld;
  logic [num_ch_p-1:0]         r_meta_sent;
  logic [metadata_width_p-1:0] r_meta [num_ch_p];
  bp_cache_ch_id_t             r_rr_ptr;
  logic                        r_err;

  logic [num_ch_p-1:0]         w_elig;
  logic [num_ch_p-1:0]         w_grant;
  logic                        w_found;
  bp_cache_ch_id_t             w_gnt_id;
  logic                        w_xfer;
  bp_cache_ch_id_t             w_mq_head;
  bp_cache_ch_id_t             w_cq_head;
  logic                        w_mq_empty;
  logic                        w_cq_empty;
  logic                        w_head_vld;
  logic                        w_head_sent;
  logic [metadata_width_p-1:0] w_meta_head;
  logic                        w_meta_emit;
  logic                        w_cmpl_ok;
  logic                        w_cmpl_err;
  logic [num_ch_p-1:0]         w_complete;
  logic [num_ch_p-1:0]         w_meta_err;

  // r_active keeps every output quiet for the first cycle after reset release
  assign w_elig = cache_req_v_i & ~r_pending & {num_ch_p{r_active}};

  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    for (int k = 0; k < num_ch_p; k++) begin
      for (int i = 0; i < num_ch_p; i++) begin
        if (!w_found && w_elig[i] && (((int'(r_rr_ptr) + k) % num_ch_p) == i)) begin
          w_found  = 1'b1;
          w_gnt_id = bp_cache_ch_id_t'(i);
        end
      end
    end
  end

  always_comb begin
    w_grant     = '0;
    cache_req_o = '0;
    for (int i = 0; i < num_ch_p; i++) begin
      w_grant[i] = w_found & cache_req_ready_i & (w_gnt_id == bp_cache_ch_id_t'(i));
      if (w_grant[i]) cache_req_o = cache_req_i[i*req_width_p +: req_width_p];
    end
  end

  assign w_xfer            = |w_grant;
  assign cache_req_ready_o = w_grant;
  assign cache_req_v_o     = cache_req_ready_i & (|w_elig);

  always_comb begin
    w_head_vld  = 1'b0;
    w_head_sent = 1'b0;
    w_meta_head = '0;
    for (int i = 0; i < num_ch_p; i++) begin
      if (w_mq_head == bp_cache_ch_id_t'(i)) begin
        w_head_vld  = r_meta_vld[i];
        w_meta_head = r_meta[i];
      end
      if (w_cq_head == bp_cache_ch_id_t'(i)) w_head_sent = r_meta_sent[i];
    end
  end

  assign w_meta_emit = r_active & ~w_mq_empty & w_head_vld;
  assign w_cmpl_ok   = r_active & cache_req_complete_i & ~w_cq_empty & w_head_sent;
  assign w_cmpl_err  = r_active & cache_req_complete_i & (w_cq_empty | ~w_head_sent);
  assign w_meta_err  = cache_req_metadata_v_i & {num_ch_p{r_active}} & (~r_pending | r_meta_vld);

  always_comb begin
    w_complete = '0;
    for (int i = 0; i < num_ch_p; i++)
      w_complete[i] = w_cmpl_ok & (w_cq_head == bp_cache_ch_id_t'(i));
  end

  assign cache_req_metadata_v_o = w_meta_emit;
  assign cache_req_metadata_o   = w_meta_emit ? w_meta_head : '0;
  assign cache_req_complete_o   = w_complete;
  assign owner_o                = w_cq_empty ? '0 : w_cq_head[ch_id_width_lp-1:0];
  assign busy_o                 = |r_pending;
  assign err_o                  = r_err;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_active    <= 1'b0;
      r_pending   <= '0;
      r_meta_vld  <= '0;
      r_meta_sent <= '0;
      r_rr_ptr    <= '0;
      r_err       <= 1'b0;
      for (int i = 0; i < num_ch_p; i++) r_meta[i] <= '0;
    end else begin
      r_active <= 1'b1;
      for (int i = 0; i < num_ch_p; i++) begin
        if (w_grant[i]) r_pending[i] <= 1'b1;
        if (w_complete[i]) begin
          r_pending[i]   <= 1'b0;
          r_meta_sent[i] <= 1'b0;
        end
        if (w_meta_emit && (w_mq_head == bp_cache_ch_id_t'(i))) begin
          r_meta_vld[i]  <= 1'b0;
          r_meta_sent[i] <= 1'b1;
        end
        if (r_active && cache_req_metadata_v_i[i] && !w_meta_err[i]) begin
          r_meta[i]     <= cache_req_metadata_i[i*metadata_width_p +: metadata_width_p];
          r_meta_vld[i] <= 1'b1;
        end
      end
      if (w_xfer)
        r_rr_ptr <= (w_gnt_id == bp_cache_ch_id_t'(num_ch_p - 1)) ? '0 : w_gnt_id + 1'b1;
      if (w_cmpl_err || (|w_meta_err)) r_err <= 1'b1;
    end
  end

  bp_cache_req_order_fifo #(.depth_p(num_ch_p), .width_p(c_ch_id_width)) u_meta_q (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (w_xfer),
    .data_i  (w_gnt_id),
    .pop_i   (w_meta_emit),
    .data_o  (w_mq_head),
    .empty_o (w_mq_empty)
  );

  bp_cache_req_order_fifo #(.depth_p(num_ch_p), .width_p(c_ch_id_width)) u_cmpl_q (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (w_xfer),
    .data_i  (w_gnt_id),
    .pop_i   (w_cmpl_ok),
    .data_o  (w_cq_head),
    .empty_o (w_cq_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_bp_cache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_bp_cache_req_arbiter
// Brief   : Directed self-checking bench for the 4-channel cache request arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bp_cache_req_arbiter;

  localparam int c_n  = 4;
  localparam int c_rw = 64;
  localparam int c_mw = 8;

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic [c_n*c_rw-1:0] cache_req_i;
  logic [c_n-1:0]      cache_req_v_i;
  logic [c_n-1:0]      cache_req_ready_o;
  logic [c_n*c_mw-1:0] cache_req_metadata_i;
  logic [c_n-1:0]      cache_req_metadata_v_i;
  logic [c_n-1:0]      cache_req_complete_o;
  logic [c_rw-1:0]     cache_req_o;
  logic                cache_req_v_o;
  logic                cache_req_ready_i;
  logic [c_mw-1:0]     cache_req_metadata_o;
  logic                cache_req_metadata_v_o;
  logic                cache_req_complete_i;
  logic [1:0]          owner_o;
  logic                busy_o;
  logic                err_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  bp_cache_req_arbiter #(.num_ch_p(c_n), .req_width_p(c_rw), .metadata_width_p(c_mw)) dut (
    .clk_i                  (clk_i),
    .reset_i                (reset_i),
    .cache_req_i            (cache_req_i),
    .cache_req_v_i          (cache_req_v_i),
    .cache_req_ready_o      (cache_req_ready_o),
    .cache_req_metadata_i   (cache_req_metadata_i),
    .cache_req_metadata_v_i (cache_req_metadata_v_i),
    .cache_req_complete_o   (cache_req_complete_o),
    .cache_req_o            (cache_req_o),
    .cache_req_v_o          (cache_req_v_o),
    .cache_req_ready_i      (cache_req_ready_i),
    .cache_req_metadata_o   (cache_req_metadata_o),
    .cache_req_metadata_v_o (cache_req_metadata_v_o),
    .cache_req_complete_i   (cache_req_complete_i),
    .owner_o                (owner_o),
    .busy_o                 (busy_o),
    .err_o                  (err_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    cache_req_v_i          = '0;
    cache_req_metadata_v_i = '0;
    cache_req_complete_i   = 1'b0;
    cache_req_ready_i      = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b0;
    step();
    step();
    reset_i = 1'b1;
    step();
  endtask

  // Metadata pulse, one cycle for it to drain, then the completion.
  task automatic finish_ch(input int ch);
    cache_req_metadata_v_i = 4'(1 << ch);
    step();
    cache_req_metadata_v_i = '0;
    step();
    cache_req_complete_i = 1'b1;
    step();
    cache_req_complete_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i              = 1'b0;
    cache_req_i          = '0;
    cache_req_metadata_i = '0;
    idle_inputs();
    cache_req_v_i = 4'b0001;
    @(negedge clk_i);
    n_vec++;
    if ({cache_req_v_o, cache_req_ready_o, busy_o, err_o, cache_req_metadata_v_o, cache_req_complete_o, owner_o} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b rdy=%b busy=%b err=%b mv=%b cmp=%b own=%0d expected all zero",
               cache_req_v_o, cache_req_ready_o, busy_o, err_o, cache_req_metadata_v_o, cache_req_complete_o, owner_o);
    end
    step();
    reset_i = 1'b1;
    @(negedge clk_i);
    n_vec++;
    if ({cache_req_v_o, cache_req_ready_o} !== 5'd0) begin
      n_err++;
      $display("FAIL reset_first_cycle: got v=%b rdy=%b expected 0/0000", cache_req_v_o, cache_req_ready_o);
    end
    step();
    cache_req_v_i = '0;
    step();
  endtask

  task automatic test_basic();
    cache_req_i[1*c_rw +: c_rw]          = 64'h55;
    cache_req_metadata_i[1*c_mw +: c_mw] = 8'h03;
    cache_req_v_i = 4'b0010;
    @(negedge clk_i);
    n_vec++;
    if ({cache_req_v_o, cache_req_ready_o, cache_req_o} !== {1'b1, 4'b0010, 64'h55}) begin
      n_err++;
      $display("FAIL basic_grant: got v=%b rdy=%b req=%h expected 1/0010/55", cache_req_v_o, cache_req_ready_o, cache_req_o);
    end
    step();
    cache_req_v_i          = '0;
    cache_req_metadata_v_i = 4'b0010;
    @(negedge clk_i);
    n_vec++;
    if ({busy_o, cache_req_metadata_v_o} !== 2'b10) begin
      n_err++;
      $display("FAIL basic_meta_latency: got busy=%b mv=%b expected 1/0", busy_o, cache_req_metadata_v_o);
    end
    step();
    cache_req_metadata_v_i = '0;
    @(negedge clk_i);
    n_vec++;
    if ({cache_req_metadata_v_o, cache_req_metadata_o, owner_o} !== {1'b1, 8'h03, 2'd1}) begin
      n_err++;
      $display("FAIL basic_meta_out: got mv=%b md=%h own=%0d expected 1/03/1", cache_req_metadata_v_o, cache_req_metadata_o, owner_o);
    end
    step();
    cache_req_complete_i = 1'b1;
    @(negedge clk_i);
    n_vec++;
    if (cache_req_complete_o !== 4'b0010) begin
      n_err++;
      $display("FAIL basic_complete: got %b expected 0010", cache_req_complete_o);
    end
    step();
    cache_req_complete_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if ({busy_o, err_o, cache_req_complete_o} !== 6'd0) begin
      n_err++;
      $display("FAIL basic_idle: got busy=%b err=%b cmp=%b expected 0/0/0000", busy_o, err_o, cache_req_complete_o);
    end
    step();
  endtask

  // Grants every cycle while metadata follows one cycle behind and
  // completions two cycles behind that, so ch0 frees up just in time.
  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < c_n; i++) cache_req_metadata_i[i*c_mw +: c_mw] = 8'hA0 + 8'(i);
    for (int c = 0; c < 9; c++) begin
      logic [3:0] exp_rdy;
      logic [3:0] exp_cmp;
      logic       exp_mv;
      logic [7:0] exp_md;
      cache_req_v_i          = (c <= 4) ? 4'hF : 4'h0;
      cache_req_metadata_v_i = (c >= 1 && c <= 5) ? 4'(1 << ((c - 1) % 4)) : 4'h0;
      cache_req_complete_i   = (c >= 3 && c <= 7);
      exp_rdy = (c <= 4) ? 4'(1 << (c % 4)) : 4'h0;
      exp_cmp = (c >= 3 && c <= 7) ? 4'(1 << ((c - 3) % 4)) : 4'h0;
      exp_mv  = (c >= 2 && c <= 6);
      exp_md  = exp_mv ? 8'hA0 + 8'((c - 2) % 4) : 8'h00;
      @(negedge clk_i);
      n_vec++;
      if ({cache_req_ready_o, cache_req_complete_o, cache_req_metadata_v_o, cache_req_metadata_o} !==
          {exp_rdy, exp_cmp, exp_mv, exp_md}) begin
        n_err++;
        $display("FAIL fair_cycle%0d: got rdy=%b cmp=%b mv=%b md=%h expected rdy=%b cmp=%b mv=%b md=%h",
                 c, cache_req_ready_o, cache_req_complete_o, cache_req_metadata_v_o, cache_req_metadata_o,
                 exp_rdy, exp_cmp, exp_mv, exp_md);
      end
      step();
    end
    idle_inputs();
    @(negedge clk_i);
    n_vec++;
    if ({busy_o, err_o} !== 2'b00) begin
      n_err++;
      $display("FAIL fair_drained: got busy=%b err=%b expected 0/0", busy_o, err_o);
    end
    step();
  endtask

  task automatic test_out_of_order_meta();
    cache_req_metadata_i[0*c_mw +: c_mw] = 8'h11;
    cache_req_metadata_i[2*c_mw +: c_mw] = 8'h22;
    for (int c = 0; c < 10; c++) begin
      logic [3:0] exp_rdy;
      logic [3:0] exp_cmp;
      logic       exp_mv;
      logic [7:0] exp_md;
      cache_req_v_i          = (c == 0) ? 4'b0001 : (c == 1) ? 4'b0100 : 4'b0000;
      cache_req_metadata_v_i = (c == 2) ? 4'b0100 : (c == 5) ? 4'b0001 : 4'b0000;
      cache_req_complete_i   = (c == 8 || c == 9);
      exp_rdy = cache_req_v_i;
      exp_cmp = (c == 8) ? 4'b0001 : (c == 9) ? 4'b0100 : 4'b0000;
      exp_mv  = (c == 6 || c == 7);
      exp_md  = (c == 6) ? 8'h11 : (c == 7) ? 8'h22 : 8'h00;
      @(negedge clk_i);
      n_vec++;
      if ({cache_req_ready_o, cache_req_complete_o, cache_req_metadata_v_o, cache_req_metadata_o} !==
          {exp_rdy, exp_cmp, exp_mv, exp_md}) begin
        n_err++;
        $display("FAIL ooo_cycle%0d: got rdy=%b cmp=%b mv=%b md=%h expected rdy=%b cmp=%b mv=%b md=%h",
                 c, cache_req_ready_o, cache_req_complete_o, cache_req_metadata_v_o, cache_req_metadata_o,
                 exp_rdy, exp_cmp, exp_mv, exp_md);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    cache_req_ready_i = 1'b0;
    cache_req_v_i     = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      n_vec++;
      if ({cache_req_v_o, cache_req_ready_o} !== 5'd0) begin
        n_err++;
        $display("FAIL bp_stall%0d: got v=%b rdy=%b expected 0/0000", c, cache_req_v_o, cache_req_ready_o);
      end
      step();
    end
    cache_req_ready_i = 1'b1;
    @(negedge clk_i);
    n_vec++;
    if ({cache_req_v_o, cache_req_ready_o} !== 5'b10001) begin
      n_err++;
      $display("FAIL bp_release: got v=%b rdy=%b expected 1/0001", cache_req_v_o, cache_req_ready_o);
    end
    step();
    cache_req_v_i = '0;
    finish_ch(0);
  endtask

  task automatic test_blocking();
    cache_req_v_i = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      logic [3:0] exp_rdy;
      logic [3:0] exp_cmp;
      cache_req_metadata_v_i = (c == 1) ? 4'b0001 : 4'b0000;
      cache_req_complete_i   = (c == 3);
      exp_rdy = (c == 0 || c == 4) ? 4'b0001 : 4'b0000;
      exp_cmp = (c == 3) ? 4'b0001 : 4'b0000;
      @(negedge clk_i);
      n_vec++;
      if ({cache_req_ready_o, cache_req_complete_o} !== {exp_rdy, exp_cmp}) begin
        n_err++;
        $display("FAIL block_cycle%0d: got rdy=%b cmp=%b expected rdy=%b cmp=%b",
                 c, cache_req_ready_o, cache_req_complete_o, exp_rdy, exp_cmp);
      end
      step();
    end
    idle_inputs();
    finish_ch(0);
  endtask

  task automatic test_errors();
    do_reset();
    cache_req_metadata_v_i = 4'b1000;
    step();
    cache_req_metadata_v_i = '0;
    @(negedge clk_i);
    n_vec++;
    if (err_o !== 1'b1) begin
      n_err++;
      $display("FAIL err_meta_unpending: got %b expected 1", err_o);
    end
    do_reset();
    cache_req_complete_i = 1'b1;
    @(negedge clk_i);
    n_vec++;
    if ({err_o, cache_req_complete_o} !== 5'd0) begin
      n_err++;
      $display("FAIL err_empty_pre: got err=%b cmp=%b expected 0/0000", err_o, cache_req_complete_o);
    end
    step();
    cache_req_complete_i = 1'b0;
    step();
    step();
    @(negedge clk_i);
    n_vec++;
    if (err_o !== 1'b1) begin
      n_err++;
      $display("FAIL err_empty_sticky: got %b expected 1", err_o);
    end
    step();
  endtask

  task automatic test_reset_midflight();
    cache_req_v_i = 4'b0110;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      n_vec++;
      if (cache_req_ready_o !== 4'(2 << c)) begin
        n_err++;
        $display("FAIL mid_grant%0d: got %b expected %b", c, cache_req_ready_o, 4'(2 << c));
      end
      step();
    end
    cache_req_v_i = '0;
    @(negedge clk_i);
    n_vec++;
    if ({busy_o, owner_o} !== {1'b1, 2'd1}) begin
      n_err++;
      $display("FAIL mid_outstanding: got busy=%b own=%0d expected 1/1", busy_o, owner_o);
    end
    step();
    #2;
    reset_i = 1'b0;
    #1;
    n_vec++;
    if ({busy_o, err_o, owner_o} !== 4'd0) begin
      n_err++;
      $display("FAIL mid_async_clear: got busy=%b err=%b own=%0d expected 0/0/0", busy_o, err_o, owner_o);
    end
    step();
    step();
    reset_i              = 1'b1;
    cache_req_complete_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_vec++;
      if (cache_req_complete_o !== 4'd0) begin
        n_err++;
        $display("FAIL mid_no_complete%0d: got %b expected 0000", c, cache_req_complete_o);
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fairness();
    test_out_of_order_meta();
    test_backpressure();
    test_blocking();
    test_errors();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
